// File: rtl/lockin_demod.sv
// Lock-in demodulator with decimating averager.
//
// Each accepted sample asks an external DDS core for sin/cos at the current
// phase. The sample is then multiplied by both results. The products are summed
// over 2^ACC_LOG2 samples, and the two averages are published once per batch.
// The phase advances by freq_word once per accepted sample.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   freq_word           phase increment per accepted sample (unsigned, 18b)
//   sample/sample_valid signed input sample and its qualifier
//   dds_phase, dds_go   phase and single-cycle start pulse to the DDS core
//   dds_sin, dds_cos    DDS results, valid DDS_WAIT cycles after dds_go
//   i_out, q_out        batch averages of sample*sin / sample*cos
//   out_valid           one-cycle pulse when i_out/q_out update
//   busy                FSM is not idle
//   overrun             sticky: a sample arrived while busy and was dropped
module lockin_demod #(
    parameter int DDS_WAIT = 3,
    parameter int ACC_LOG2 = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic        [17:0] freq_word,
    input  logic signed [15:0] sample,
    input  logic               sample_valid,
    output logic        [17:0] dds_phase,
    output logic               dds_go,
    input  logic signed [15:0] dds_sin,
    input  logic signed [15:0] dds_cos,
    output logic signed [31:0] i_out,
    output logic signed [31:0] q_out,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun
);
    // ACC_LOG2 guard bits above the 32-bit product absorb a full batch of
    // worst-case (2^30) products without overflow.
    localparam int ACC_W = 32 + ACC_LOG2;
    localparam int CNT_W = ACC_LOG2 + 1;
    localparam int WCW   = (DDS_WAIT > 1) ? $clog2(DDS_WAIT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MUL, S_ACC} state_t;

    state_t                   state_q;
    logic [WCW-1:0]           wcnt_q;
    logic signed [15:0]       sample_q;
    logic signed [31:0]       p_i_q, p_q_q;
    logic signed [ACC_W-1:0]  acc_i_q, acc_q_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [17:0]              phase_q;
    logic                     dds_go_q, out_valid_q, overrun_q;
    logic signed [31:0]       i_out_q, q_out_q;

    logic signed [ACC_W-1:0]  acc_i_d, acc_q_d;
    logic [CNT_W-1:0]         cnt_d;
    logic                     batch_done;

    always_comb begin
        acc_i_d    = acc_i_q + ACC_W'(p_i_q);
        acc_q_d    = acc_q_q + ACC_W'(p_q_q);
        cnt_d      = cnt_q + 1'b1;
        batch_done = (cnt_d == CNT_W'(1 << ACC_LOG2));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            sample_q    <= '0;
            p_i_q       <= '0;
            p_q_q       <= '0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            cnt_q       <= '0;
            phase_q     <= '0;
            dds_go_q    <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            i_out_q     <= '0;
            q_out_q     <= '0;
        end else begin
            dds_go_q    <= 1'b0;
            out_valid_q <= 1'b0;
            // A sample offered while busy is lost; only the flag records it.
            if (sample_valid && state_q != S_IDLE) overrun_q <= 1'b1;
            case (state_q)
                S_IDLE: if (sample_valid) begin
                    sample_q <= sample;
                    dds_go_q <= 1'b1;
                    wcnt_q   <= '0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if (wcnt_q == WCW'(DDS_WAIT - 1)) state_q <= S_MUL;
                    else                              wcnt_q  <= wcnt_q + 1'b1;
                end
                S_MUL: begin
                    p_i_q   <= 32'(sample_q) * 32'(dds_sin);
                    p_q_q   <= 32'(sample_q) * 32'(dds_cos);
                    state_q <= S_ACC;
                end
                S_ACC: begin
                    phase_q <= phase_q + freq_word;
                    state_q <= S_IDLE;
                    if (batch_done) begin
                        // Arithmetic shift gives floor division of the batch sum.
                        i_out_q     <= 32'(acc_i_d >>> ACC_LOG2);
                        q_out_q     <= 32'(acc_q_d >>> ACC_LOG2);
                        out_valid_q <= 1'b1;
                        acc_i_q     <= '0;
                        acc_q_q     <= '0;
                        cnt_q       <= '0;
                    end else begin
                        acc_i_q <= acc_i_d;
                        acc_q_q <= acc_q_d;
                        cnt_q   <= cnt_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dds_phase = phase_q;
    assign dds_go    = dds_go_q;
    assign i_out     = i_out_q;
    assign q_out     = q_out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_lockin_demod.sv
// Scoreboard bench for lockin_demod. The driver's reference model keeps
// running sums per batch. It treats the block as busy for DDS_WAIT+2 cycles
// after each accept. It pushes the expected dds_go pulses and batch averages.
// The monitor compares these with what the DUT presents.
module tb_lockin_demod;
    localparam int DDS_WAIT = 3;
    localparam int ACC_LOG2 = 2;
    localparam int NACC     = 1 << ACC_LOG2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic        [17:0] freq_word = '0;
    logic signed [15:0] sample = '0;
    logic               sample_valid = 1'b1;
    logic signed [15:0] dds_sin = '0, dds_cos = '0;
    logic        [17:0] dds_phase;
    logic               dds_go, out_valid, busy, overrun;
    logic signed [31:0] i_out, q_out;

    lockin_demod #(.DDS_WAIT(DDS_WAIT), .ACC_LOG2(ACC_LOG2)) dut (
        .clk(clk), .rst_n(rst_n), .freq_word(freq_word), .sample(sample),
        .sample_valid(sample_valid), .dds_phase(dds_phase), .dds_go(dds_go),
        .dds_sin(dds_sin), .dds_cos(dds_cos), .i_out(i_out), .q_out(q_out),
        .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", name, edge_cnt, act, exp);
        end
    endtask

    // DDS stand-in: either a phase hash or forced constants.
    bit                 frc = 1'b0;
    logic signed [15:0] frc_sin = '0, frc_cos = '0;

    function automatic logic [31:0] dds_fn(input logic [17:0] ph);
        logic [31:0] h;
        if (frc) return {frc_sin, frc_cos};
        h = {14'd0, ph} * 32'h9E3779B1;
        h = h ^ (h >> 13);
        return h;
    endfunction

    // Junk until DDS_WAIT edges after dds_go, then the real result.
    always @(posedge clk) begin
        #1;
        if (dds_go) begin
            {dds_sin, dds_cos} = $urandom;
            repeat (DDS_WAIT) @(posedge clk);
            #1 {dds_sin, dds_cos} = dds_fn(dds_phase);
        end
    end

    // Reference model state.
    typedef struct { int e; longint a; longint b; } ev_t;
    ev_t go_q[$], out_q[$];
    int          la = -100;
    bit          pend = 0, ov_m = 0;
    longint      ms = 0, msin = 0, mcos = 0, acc_i = 0, acc_q = 0;
    int          cnt = 0;
    longint      phase_m = 0;
    bit          fw_rand = 1'b1;
    logic [17:0] fw_fix = '0;

    function automatic longint fdiv(input longint a);
        longint q = a / NACC;
        if ((a % NACC) != 0 && a < 0) q -= 1;
        return q;
    endfunction

    // Drive inputs for the next edge k and advance the model across edge k.
    task automatic step(input bit v, input logic signed [15:0] s, input bit r);
        int k;
        logic [31:0] sc;
        logic [17:0] fw;
        @(negedge clk);
        k  = edge_cnt + 1;
        fw = fw_rand ? 18'($urandom) : fw_fix;
        rst_n = r; sample_valid = v; sample = s; freq_word = fw;
        if (!r) begin
            la = -100; pend = 0; ov_m = 0; phase_m = 0;
            acc_i = 0; acc_q = 0; cnt = 0;
        end else begin
            if (pend && k == la + DDS_WAIT + 2) begin
                acc_i += ms * msin;
                acc_q += ms * mcos;
                cnt++;
                phase_m = (phase_m + longint'(fw)) % (1 << 18);
                pend = 0;
                if (cnt == NACC) begin
                    out_q.push_back('{k, fdiv(acc_i), fdiv(acc_q)});
                    acc_i = 0; acc_q = 0; cnt = 0;
                end
            end
            if (v) begin
                if (k - la >= DDS_WAIT + 3) begin
                    la = k; pend = 1; ms = longint'(s);
                    sc = dds_fn(18'(phase_m));
                    msin = longint'($signed(sc[31:16]));
                    mcos = longint'($signed(sc[15:0]));
                    go_q.push_back('{k, phase_m, 0});
                end else ov_m = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b1);
    endtask

    task automatic smp(input logic signed [15:0] s);
        step(1'b1, s, 1'b1);
        idle(DDS_WAIT + 2);
    endtask

    task automatic do_reset();
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
    endtask

    // Monitor: sampled 1 time unit after each active edge.
    longint hold_i = 0, hold_q = 0;
    always @(posedge clk) begin
        ev_t ev;
        int  d;
        #1;
        if (!rst_n) begin
            hold_i = 0; hold_q = 0;
            chk("rst_dds_go", dds_go, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_dds_phase", dds_phase, 0);
        end
        if (dds_go) begin
            if (go_q.size() == 0) chk("unexpected_dds_go", 1, 0);
            else begin
                ev = go_q.pop_front();
                chk("dds_go_edge", edge_cnt, ev.e);
                chk("dds_phase", dds_phase, ev.a);
            end
        end else if (go_q.size() > 0 && go_q[0].e < edge_cnt) begin
            ev = go_q.pop_front();
            chk("missing_dds_go", 0, 1);
        end
        if (out_valid) begin
            if (out_q.size() == 0) chk("unexpected_out_valid", 1, 0);
            else begin
                ev = out_q.pop_front();
                chk("out_edge", edge_cnt, ev.e);
                hold_i = ev.a; hold_q = ev.b;
            end
        end else if (out_q.size() > 0 && out_q[0].e < edge_cnt) begin
            ev = out_q.pop_front();
            chk("missing_out_valid", 0, 1);
        end
        d = edge_cnt - la;
        chk("busy", busy, (d >= 0 && d <= DDS_WAIT + 1) ? 1 : 0);
        chk("overrun", overrun, ov_m);
        chk("i_out", i_out, hold_i);
        chk("q_out", q_out, hold_q);
    end

    initial begin
        // Reset held for two edges with sample_valid high.
        step(1'b1, 16'sd1234, 1'b0);
        idle(2);

        // Latency / basic products.
        frc = 1; frc_sin = 16'sd16384; frc_cos = -16'sd16384;
        repeat (NACC) smp(16'sd1000);

        // Decimation and floor.
        frc_sin = 16'sd1000; frc_cos = 16'sd7;
        smp(16'sd100); smp(16'sd200); smp(16'sd300); smp(16'sd400);
        frc_sin = 16'sd1; frc_cos = 16'sd3;
        smp(-16'sd1); smp(-16'sd1); smp(-16'sd1); smp(-16'sd2);

        // Full-scale products.
        frc_sin = -16'sd32768; frc_cos = 16'sd32767;
        repeat (NACC) smp(-16'sd32768);

        // Overrun: second sample two edges after the first is dropped.
        do_reset();
        frc_sin = 16'sd321; frc_cos = -16'sd77;
        step(1'b1, 16'sd5, 1'b1); idle(1);
        step(1'b1, 16'sd9, 1'b1); idle(DDS_WAIT + 1);
        repeat (NACC - 1) smp(16'sd5);
        idle(4);

        // Phase wrap.
        do_reset();
        frc = 0; fw_rand = 0; fw_fix = 18'h20000;
        repeat (3) smp(16'sd77);

        // Reset during WAIT, then a clean batch.
        do_reset();
        fw_rand = 1;
        smp(16'sd11);
        step(1'b1, 16'sd500, 1'b1); idle(1);
        step(1'b0, '0, 1'b0);
        repeat (NACC) smp(-16'sd3000);

        // Random traffic with occasional resets.
        for (int n = 0; n < 800; n++) begin
            logic signed [15:0] s;
            s = ($urandom % 8 == 0) ? -16'sd32768 : 16'($urandom);
            step(($urandom % 3) == 0, s, ($urandom % 150) != 0);
        end
        idle(12);
        chk("go_queue_drained", go_q.size(), 0);
        chk("out_queue_drained", out_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lockin_demod.md
LOCKIN_DEMOD -- requirements
Module: lockin_demod

Interface
REQ-001 Parameter DDS_WAIT, default 3: cycles waited after the dds_go pulse before sin/cos are valid.
REQ-002 Parameter ACC_LOG2, default 8: log2 of the number of products accumulated per output.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 freq_word  in  18  unsigned phase increment per accepted sample.
REQ-006 sample  in  16  signed two's-complement input sample.
REQ-007 sample_valid  in  1  sample qualifier; one sample per high cycle.
REQ-008 dds_phase  out  18  phase to the DDS core.
REQ-009 dds_go  out  1  registered single-cycle DDS start pulse.
REQ-010 dds_sin  in  16  signed DDS sine result.
REQ-011 dds_cos  in  16  signed DDS cosine result.
REQ-012 i_out  out  32  signed in-phase average, sample x sin.
REQ-013 q_out  out  32  signed quadrature average, sample x cos.
REQ-014 out_valid  out  1  single-cycle pulse; i_out/q_out are new.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 overrun  out  1  sticky flag for a dropped sample.

Function
REQ-017 FSM states are IDLE, WAIT, MUL and ACC; the FSM leaves reset in IDLE.
REQ-018 At edge e0, in IDLE with sample_valid=1: latch sample, set dds_go<=1, clear the wait counter, go to WAIT.
REQ-019 dds_go clears at e1, so it is high exactly one cycle per accepted sample.
REQ-020 WAIT lasts exactly DDS_WAIT cycles (e1..e3 at the default), then goes to MUL.
REQ-021 In MUL (edge e4): register p_i = sample_r*dds_sin and p_q = sample_r*dds_cos as 32-bit signed values; go to ACC.
REQ-022 In ACC (edge e5): add p_i/p_q into acc_i/acc_q (width 32+ACC_LOG2, signed), increment the sample count, go to IDLE.
REQ-023 In ACC: phase_acc <= phase_acc + freq_word mod 2^18, with freq_word sampled at e5 only.
REQ-024 dds_phase equals phase_acc and is stable from e0 through e4.
REQ-025 When the count reaches 2^ACC_LOG2 at e5: i_out/q_out <= (acc + p) arithmetic-shifted right by ACC_LOG2 (floor), out_valid<=1 for one cycle, acc and count <= 0.
REQ-026 The next sample can be accepted at e6; the minimum accepted-sample spacing is DDS_WAIT+3 cycles.
REQ-027 sample_valid while busy: the sample is dropped, overrun<=1, and accumulation, phase and FSM are unaffected.
REQ-028 overrun clears only on reset.
REQ-029 Full-scale product (-32768 x -32768 = 2^30) and worst-case accumulation SHALL NOT overflow.
REQ-030 i_out/q_out hold their value between out_valid pulses.

Reset
REQ-031 rst_n=0 at any edge: FSM to IDLE; dds_go, out_valid, busy, overrun, i_out, q_out, dds_phase, phase_acc, acc_i, acc_q, count, p_i and p_q all to 0.
REQ-032 Reset mid-operation discards the partial accumulation; no out_valid is produced for the interrupted batch.

Verification
REQ-033 Reset: hold rst_n=0 for 2 cycles with sample_valid=1 -> all outputs 0, dds_go never asserted.
REQ-034 Latency (ACC_LOG2=0): sample=1000 at e0, model sin=16384, cos=-16384 valid from e3 -> dds_go high e0..e1 only, out_valid after e5, i_out=16384000, q_out=-16384000.
REQ-035 Decimation/floor (ACC_LOG2=2): samples 100,200,300,400 with sin=1000 -> i_out=250000; samples -1,-1,-1,-2 with sin=1 -> i_out=-2.
REQ-036 Overrun: second sample_valid at e2 -> no second dds_go, overrun=1 and stays 1, i_out equals the single-sample result.
REQ-037 Phase wrap: freq_word=0x20000, three samples -> dds_phase=0x00000, 0x20000, 0x00000 at successive dds_go pulses.
REQ-038 Reset mid-op: rst_n=0 during WAIT -> busy=0 next cycle, no out_valid; the following batch starts from acc=0 and dds_phase=0.
